// File: rtl/cache_tag_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cache_tag_ctrl_pkg
// Shared constants for the L1 tag-side controller: address field widths,
// associativity, FSM state encoding and a small priority-encode helper.
// No ports (package).
// ---------------------------------------------------------------------------
package cache_tag_ctrl_pkg;

  // Address split: addr[31:12] tag, addr[11:5] set index, addr[4:0] offset.
  localparam int TAG_W = 20;
  localparam int IDX_W = 7;
  localparam int OFF_W = 5;
  localparam int SETS  = 1 << IDX_W;
  localparam int WAYS  = 4;
  localparam int WAY_W = 2;

  // FSM state encoding, kept as plain constants for legacy tool flows.
  localparam int          ST_W      = 3;
  localparam logic [2:0]  ST_IDLE   = 3'd0;
  localparam logic [2:0]  ST_LOOKUP = 3'd1;
  localparam logic [2:0]  ST_RESP   = 3'd2;
  localparam logic [2:0]  ST_REFILL = 3'd3;
  localparam logic [2:0]  ST_FILL   = 3'd4;

  // Index of the lowest set bit; returns 0 when no bit is set, so callers
  // must qualify the result with a reduction-OR of the vector.
  function automatic logic [WAY_W-1:0] lowestWay(input logic [WAYS-1:0] vec);
    logic [WAY_W-1:0] way;
    way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (vec[w]) begin
        way = WAY_W'(w);
      end
    end
    return way;
  endfunction

endpackage

// File: rtl/cache_tag_ctrl_plru_tree4.sv
// ---------------------------------------------------------------------------
// plru_tree4
// Tree pseudo-LRU for one 4-way set (purely combinational).
//   i_bits      : current tree bits {b2, b1, b0} of the set
//   i_accessWay : way being touched (hit or freshly filled)
//   o_victim    : way the tree points at as least recently used
//   o_nextBits  : tree bits after marking i_accessWay most recently used
// ---------------------------------------------------------------------------
module plru_tree4
  import cache_tag_ctrl_pkg::*;
(
  input  logic [2:0]       i_bits,
  input  logic [WAY_W-1:0] i_accessWay,
  output logic [WAY_W-1:0] o_victim,
  output logic [2:0]       o_nextBits
);

  // b0 picks the half, b1/b2 pick the way inside the lower/upper half.
  // Touching a way points every bit on its path away from it.
  always_comb begin
    o_victim   = i_bits[0] ? {1'b1, i_bits[2]} : {1'b0, i_bits[1]};
    o_nextBits = i_bits;
    o_nextBits[0] = ~i_accessWay[1];
    if (!i_accessWay[1]) begin
      o_nextBits[1] = ~i_accessWay[0];
    end else begin
      o_nextBits[2] = ~i_accessWay[0];
    end
  end

endmodule

// File: rtl/cache_tag_ctrl.sv
// ---------------------------------------------------------------------------
// cache_tag_ctrl
// Tag-side controller of the 4-way, 128-set L1 cache. Takes one lookup at a
// time, reads the four external tag arrays, owns the per-set valid bits and
// PLRU state, reports hit/way or a victim, and writes the new tag into the
// victim way once the data path reports the refill finished.
//
// Ports
//   clk, rst_n              : clock, asynchronous active-low reset
//   i_req_valid/o_req_ready : lookup request handshake (ready only in IDLE)
//   i_req_addr              : byte address, captured on the handshake
//   o_resp_valid/i_resp_ready : lookup result handshake
//   o_resp_hit, o_resp_way  : hit flag, hit way or victim way
//   o_resp_victim_valid/_tag: victim held a valid line / its stored tag
//   i_refill_done           : one-cycle pulse, miss block refilled
//   o_ta_raddr, i_ta_rdata0..3 : shared read index, per-way read data
//   o_ta_waddr, o_ta_wen, o_ta_wdata : tag array write port (one-hot way)
// ---------------------------------------------------------------------------
module cache_tag_ctrl
  import cache_tag_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [31:0]      i_req_addr,
  output logic             o_resp_valid,
  input  logic             i_resp_ready,
  output logic             o_resp_hit,
  output logic [WAY_W-1:0] o_resp_way,
  output logic             o_resp_victim_valid,
  output logic [TAG_W-1:0] o_resp_victim_tag,
  input  logic             i_refill_done,
  output logic [IDX_W-1:0] o_ta_raddr,
  input  logic [TAG_W-1:0] i_ta_rdata0,
  input  logic [TAG_W-1:0] i_ta_rdata1,
  input  logic [TAG_W-1:0] i_ta_rdata2,
  input  logic [TAG_W-1:0] i_ta_rdata3,
  output logic [IDX_W-1:0] o_ta_waddr,
  output logic [WAYS-1:0]  o_ta_wen,
  output logic [TAG_W-1:0] o_ta_wdata
);

  logic [ST_W-1:0]  r_state;
  logic [ST_W-1:0]  w_nextState;
  logic             r_reqReady;
  logic [TAG_W-1:0] r_reqTag;
  logic [IDX_W-1:0] r_reqIdx;
  logic             r_respHit;
  logic [WAY_W-1:0] r_respWay;
  logic             r_victimValid;
  logic [TAG_W-1:0] r_victimTag;

  logic [WAYS-1:0]  r_valid [SETS];
  logic [2:0]       r_plru  [SETS];

  logic             w_reqFire;
  logic             w_lookupHit;
  logic [TAG_W-1:0] w_rdata [WAYS];
  logic [WAYS-1:0]  w_setValid;
  logic [2:0]       w_setPlru;
  logic [WAYS-1:0]  w_hitVec;
  logic             w_anyHit;
  logic             w_anyInvalid;
  logic [WAY_W-1:0] w_hitWay;
  logic [WAY_W-1:0] w_invalidWay;
  logic [WAY_W-1:0] w_plruVictim;
  logic [WAY_W-1:0] w_victimWay;
  logic [WAY_W-1:0] w_accessWay;
  logic [2:0]       w_nextPlru;
  logic             w_unusedOffset;

  // The block offset plays no part in tag handling.
  assign w_unusedOffset = ^i_req_addr[OFF_W-1:0];

  assign w_rdata[0] = i_ta_rdata0;
  assign w_rdata[1] = i_ta_rdata1;
  assign w_rdata[2] = i_ta_rdata2;
  assign w_rdata[3] = i_ta_rdata3;

  assign w_reqFire  = r_reqReady && i_req_valid;
  assign w_setValid = r_valid[r_reqIdx];
  assign w_setPlru  = r_plru[r_reqIdx];

  // Tag compare against the asynchronously read arrays; lowest way wins if
  // more than one way claims the tag.
  always_comb begin
    w_hitVec = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_hitVec[w] = w_setValid[w] && (w_rdata[w] == r_reqTag);
    end
  end

  assign w_anyHit     = |w_hitVec;
  assign w_hitWay     = lowestWay(w_hitVec);
  assign w_anyInvalid = ~&w_setValid;
  assign w_invalidWay = lowestWay(~w_setValid);
  assign w_victimWay  = w_anyInvalid ? w_invalidWay : w_plruVictim;
  assign w_lookupHit  = (r_state == ST_LOOKUP) && w_anyHit;

  // One tree instance serves both PLRU updates: the hit way during LOOKUP and
  // the registered victim way during FILL.
  assign w_accessWay = (r_state == ST_FILL) ? r_respWay : w_hitWay;

  plru_tree4 u_plru (
    .i_bits      (w_setPlru),
    .i_accessWay (w_accessWay),
    .o_victim    (w_plruVictim),
    .o_nextBits  (w_nextPlru)
  );

  // FSM transitions; a refill_done pulse outside REFILL is simply not looked at.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:   if (w_reqFire)     w_nextState = ST_LOOKUP;
      ST_LOOKUP:                    w_nextState = ST_RESP;
      ST_RESP:   if (i_resp_ready)  w_nextState = r_respHit ? ST_IDLE : ST_REFILL;
      ST_REFILL: if (i_refill_done) w_nextState = ST_FILL;
      ST_FILL:                      w_nextState = ST_IDLE;
      default:                      w_nextState = ST_IDLE;
    endcase
  end

  // State, request capture and the registered lookup result. req_ready is
  // registered so it stays low while reset is held and only rises on the
  // first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_reqReady    <= 1'b0;
      r_reqTag      <= '0;
      r_reqIdx      <= '0;
      r_respHit     <= 1'b0;
      r_respWay     <= '0;
      r_victimValid <= 1'b0;
      r_victimTag   <= '0;
    end else begin
      r_state    <= w_nextState;
      r_reqReady <= (w_nextState == ST_IDLE);
      if (w_reqFire) begin
        r_reqTag <= i_req_addr[31 -: TAG_W];
        r_reqIdx <= i_req_addr[OFF_W +: IDX_W];
      end
      if (r_state == ST_LOOKUP) begin
        if (w_anyHit) begin
          r_respHit     <= 1'b1;
          r_respWay     <= w_hitWay;
          r_victimValid <= 1'b0;
          r_victimTag   <= '0;
        end else begin
          r_respHit     <= 1'b0;
          r_respWay     <= w_victimWay;
          r_victimValid <= w_setValid[w_victimWay];
          r_victimTag   <= w_rdata[w_victimWay];
        end
      end
    end
  end

  // Per-set valid bits and PLRU trees. Both are wiped by reset so a lookup
  // after reset can never hit on stale array contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_plru[s]  <= '0;
      end
    end else begin
      if (w_lookupHit || (r_state == ST_FILL)) begin
        r_plru[r_reqIdx] <= w_nextPlru;
      end
      if (r_state == ST_FILL) begin
        r_valid[r_reqIdx][r_respWay] <= 1'b1;
      end
    end
  end

  assign o_req_ready         = r_reqReady;
  assign o_resp_valid        = (r_state == ST_RESP);
  assign o_resp_hit          = r_respHit;
  assign o_resp_way          = r_respWay;
  assign o_resp_victim_valid = r_victimValid;
  assign o_resp_victim_tag   = r_victimTag;

  // Read and write indices both come from the captured request; the write
  // enable is the only thing that gates an actual array update.
  assign o_ta_raddr = r_reqIdx;
  assign o_ta_waddr = r_reqIdx;
  assign o_ta_wdata = r_reqTag;
  assign o_ta_wen   = (r_state == ST_FILL) ? (WAYS'(1) << r_respWay) : '0;

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cache_tag_ctrl
// Directed bench for cache_tag_ctrl. The bench plays the four external tag
// arrays, pushes hand-computed responses and tag writes into queues when it
// issues stimulus, and a negedge monitor pops and compares them whenever the
// DUT completes a response handshake or drives a tag write.
// ---------------------------------------------------------------------------
module tb_cache_tag_ctrl;
  import cache_tag_ctrl_pkg::*;

  typedef struct {
    logic             hit;
    logic [WAY_W-1:0] way;
    logic             vv;
    logic [TAG_W-1:0] vtag;
  } respT;

  typedef struct {
    logic [WAYS-1:0]  wen;
    logic [IDX_W-1:0] waddr;
    logic [TAG_W-1:0] wdata;
  } fillT;

  logic             clk;
  logic             rst_n;
  logic             reqValid;
  logic             reqReady;
  logic [31:0]      reqAddr;
  logic             respValid;
  logic             respReady;
  logic             respHit;
  logic [WAY_W-1:0] respWay;
  logic             respVictimValid;
  logic [TAG_W-1:0] respVictimTag;
  logic             refillDone;
  logic [IDX_W-1:0] taRaddr;
  logic [TAG_W-1:0] taRdata0, taRdata1, taRdata2, taRdata3;
  logic [IDX_W-1:0] taWaddr;
  logic [WAYS-1:0]  taWen;
  logic [TAG_W-1:0] taWdata;

  logic [TAG_W-1:0] tagMem [WAYS][SETS];
  logic             memClear;

  respT expResp[$];
  fillT expFill[$];
  int   nChecks = 0;
  int   nErrors = 0;

  cache_tag_ctrl dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .i_req_valid         (reqValid),
    .o_req_ready         (reqReady),
    .i_req_addr          (reqAddr),
    .o_resp_valid        (respValid),
    .i_resp_ready        (respReady),
    .o_resp_hit          (respHit),
    .o_resp_way          (respWay),
    .o_resp_victim_valid (respVictimValid),
    .o_resp_victim_tag   (respVictimTag),
    .i_refill_done       (refillDone),
    .o_ta_raddr          (taRaddr),
    .i_ta_rdata0         (taRdata0),
    .i_ta_rdata1         (taRdata1),
    .i_ta_rdata2         (taRdata2),
    .i_ta_rdata3         (taRdata3),
    .o_ta_waddr          (taWaddr),
    .o_ta_wen            (taWen),
    .o_ta_wdata          (taWdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External tag arrays: asynchronous read, write on the rising edge.
  assign taRdata0 = tagMem[0][taRaddr];
  assign taRdata1 = tagMem[1][taRaddr];
  assign taRdata2 = tagMem[2][taRaddr];
  assign taRdata3 = tagMem[3][taRaddr];

  always @(posedge clk) begin
    if (memClear) begin
      for (int w = 0; w < WAYS; w++)
        for (int s = 0; s < SETS; s++)
          tagMem[w][s] <= '0;
    end else begin
      for (int w = 0; w < WAYS; w++)
        if (taWen[w]) tagMem[w][taWaddr] <= taWdata;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  function automatic respT mkResp(input logic hit, input logic [WAY_W-1:0] way,
                                  input logic vv, input logic [TAG_W-1:0] vtag);
    respT r;
    r.hit  = hit;
    r.way  = way;
    r.vv   = vv;
    r.vtag = vtag;
    return r;
  endfunction

  // Monitor: compare each accepted response and each tag write to the queues.
  always @(negedge clk) begin
    respT e;
    fillT f;
    if (rst_n && respValid && respReady) begin
      if (expResp.size() == 0) begin
        checkOutput("unexpected_resp", 32'(respValid), 32'(0));
      end else begin
        e = expResp.pop_front();
        checkOutput("resp_hit", 32'(respHit), 32'(e.hit));
        checkOutput("resp_way", 32'(respWay), 32'(e.way));
        checkOutput("resp_victim_valid", 32'(respVictimValid), 32'(e.vv));
        checkOutput("resp_victim_tag", 32'(respVictimTag), 32'(e.vtag));
      end
    end
    if (taWen != '0) begin
      if (expFill.size() == 0) begin
        checkOutput("unexpected_ta_wen", 32'(taWen), 32'(0));
      end else begin
        f = expFill.pop_front();
        checkOutput("ta_wen", 32'(taWen), 32'(f.wen));
        checkOutput("ta_waddr", 32'(taWaddr), 32'(f.waddr));
        checkOutput("ta_wdata", 32'(taWdata), 32'(f.wdata));
      end
    end
  end

  task automatic checkResetOutputs(input string tagName);
    checkOutput({tagName, "_req_ready"}, 32'(reqReady), 32'(0));
    checkOutput({tagName, "_resp_valid"}, 32'(respValid), 32'(0));
    checkOutput({tagName, "_resp_hit"}, 32'(respHit), 32'(0));
    checkOutput({tagName, "_resp_way"}, 32'(respWay), 32'(0));
    checkOutput({tagName, "_victim_valid"}, 32'(respVictimValid), 32'(0));
    checkOutput({tagName, "_victim_tag"}, 32'(respVictimTag), 32'(0));
    checkOutput({tagName, "_ta_wen"}, 32'(taWen), 32'(0));
    checkOutput({tagName, "_ta_raddr"}, 32'(taRaddr), 32'(0));
    checkOutput({tagName, "_ta_waddr"}, 32'(taWaddr), 32'(0));
    checkOutput({tagName, "_ta_wdata"}, 32'(taWdata), 32'(0));
  endtask

  // One lookup: wait for ready, handshake, check 2-cycle latency, optionally
  // stall the response (and fire a stray refill_done meanwhile), then accept.
  task automatic applyStimulus(input logic [31:0] addr, input respT exp,
                               input int stall, input bit strayPulse);
    int waitCycles = 0;
    while (!reqReady && waitCycles < 50) begin
      @(posedge clk); #1;
      waitCycles++;
    end
    if (!reqReady) begin
      checkOutput("req_ready_timeout", 32'(reqReady), 32'(1));
      return;
    end
    expResp.push_back(exp);
    reqValid = 1'b1;
    reqAddr  = addr;
    @(posedge clk); #1;
    reqValid = 1'b0;
    checkOutput("lookup_cycle_resp_valid", 32'(respValid), 32'(0));
    checkOutput("lookup_cycle_req_ready", 32'(reqReady), 32'(0));
    @(posedge clk); #1;
    checkOutput("resp_valid_latency", 32'(respValid), 32'(1));
    for (int i = 0; i < stall; i++) begin
      refillDone = strayPulse && (i == 1);
      @(posedge clk); #1;
      checkOutput("stall_resp_valid", 32'(respValid), 32'(1));
      checkOutput("stall_req_ready", 32'(reqReady), 32'(0));
      checkOutput("stall_resp_hit", 32'(respHit), 32'(exp.hit));
      checkOutput("stall_resp_way", 32'(respWay), 32'(exp.way));
      checkOutput("stall_victim_tag", 32'(respVictimTag), 32'(exp.vtag));
    end
    refillDone = 1'b0;
    respReady  = 1'b1;
    @(posedge clk); #1;
    respReady  = 1'b0;
    checkOutput("resp_drained", 32'(expResp.size()), 32'(0));
  endtask

  task automatic doRefill(input logic [WAY_W-1:0] way, input logic [IDX_W-1:0] idx,
                          input logic [TAG_W-1:0] tag);
    fillT f;
    f.wen   = WAYS'(1) << way;
    f.waddr = idx;
    f.wdata = tag;
    expFill.push_back(f);
    refillDone = 1'b1;
    @(posedge clk); #1;
    refillDone = 1'b0;
    @(posedge clk); #1;
    checkOutput("fill_seen", 32'(expFill.size()), 32'(0));
    checkOutput("req_ready_after_fill", 32'(reqReady), 32'(1));
  endtask

  task automatic doReset(input string tagName);
    rst_n = 1'b0;
    #1;
    checkResetOutputs(tagName);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput({tagName, "_ready_after_release"}, 32'(reqReady), 32'(1));
  endtask

  // Fill ways 0..3 of set 0x33 with tags 1..4; arguments are the tags the
  // arrays held beforehand (reported as victim tags of invalid ways).
  task automatic fillFour(input logic [TAG_W-1:0] old0, input logic [TAG_W-1:0] old1,
                          input logic [TAG_W-1:0] old2, input logic [TAG_W-1:0] old3);
    logic [TAG_W-1:0] oldTags [WAYS];
    oldTags[0] = old0; oldTags[1] = old1; oldTags[2] = old2; oldTags[3] = old3;
    for (int t = 1; t <= 4; t++) begin
      applyStimulus({TAG_W'(t), 7'h33, 5'h00},
                    mkResp(1'b0, WAY_W'(t - 1), 1'b0, oldTags[t-1]), 0, 1'b0);
      doRefill(WAY_W'(t - 1), 7'h33, TAG_W'(t));
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    reqValid   = 1'b0;
    reqAddr    = '0;
    respReady  = 1'b0;
    refillDone = 1'b0;
    memClear   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    memClear = 1'b0;
    checkResetOutputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("ready_after_reset", 32'(reqReady), 32'(1));

    $display("[TB] first miss and fill of 0x12345678");
    applyStimulus(32'h1234_5678, mkResp(1'b0, 2'd0, 1'b0, 20'h0), 0, 1'b0);
    doRefill(2'd0, 7'h33, 20'h12345);

    $display("[TB] repeat lookup hits");
    applyStimulus(32'h1234_5678, mkResp(1'b1, 2'd0, 1'b0, 20'h0), 0, 1'b0);

    $display("[TB] full set, miss picks PLRU way 0");
    doReset("reset2");
    fillFour(20'h12345, 20'h0, 20'h0, 20'h0);
    applyStimulus({20'h00005, 7'h33, 5'h00}, mkResp(1'b0, 2'd0, 1'b1, 20'h00001), 0, 1'b0);

    $display("[TB] reset while in REFILL");
    doReset("reset_in_refill");
    applyStimulus(32'h1234_5678, mkResp(1'b0, 2'd0, 1'b0, 20'h00001), 0, 1'b0);
    doRefill(2'd0, 7'h33, 20'h12345);

    $display("[TB] hit way 0 then miss picks way 2 under backpressure");
    doReset("reset3");
    fillFour(20'h12345, 20'h00002, 20'h00003, 20'h00004);
    applyStimulus({20'h00001, 7'h33, 5'h00}, mkResp(1'b1, 2'd0, 1'b0, 20'h0), 0, 1'b0);
    applyStimulus({20'h00006, 7'h33, 5'h00}, mkResp(1'b0, 2'd2, 1'b1, 20'h00003), 5, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("refill_wait_req_ready", 32'(reqReady), 32'(0));
      checkOutput("refill_wait_ta_wen", 32'(taWen), 32'(0));
    end
    doRefill(2'd2, 7'h33, 20'h00006);
    applyStimulus({20'h00006, 7'h33, 5'h00}, mkResp(1'b1, 2'd2, 1'b0, 20'h0), 0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("resp_queue_empty", 32'(expResp.size()), 32'(0));
    checkOutput("fill_queue_empty", 32'(expFill.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
